inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch.sv | 94 +++++++++
 tb/tb_inst_fetch.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// inst_fetch: pipelined instruction fetch with one-cycle memory latency and a 2-entry output FIFO.
// Ports:
//   clock_i          rising-edge clock
//   reset_n_i        asynchronous active-low reset
//   fetch_en_i       allow new fetch requests
//   redirect_valid_i flush and restart fetch at redirect_pc_i
//   redirect_pc_i    redirect byte address (bits [1:0] ignored)
//   mem_address_o    word address to instruction memory (fetch_pc[11:2])
//   mem_q_i          memory data for the address sampled on the previous edge
//   out_valid_o      FIFO head valid
//   out_ready_i      decode accepts the head
//   out_inst_o       head instruction word
//   out_pc_o         head byte address
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock_i,
    input  logic        reset_n_i,
    input  logic        fetch_en_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    output logic [9:0]  mem_address_o,
    input  logic [31:0] mem_q_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_inst_o,
    output logic [31:0] out_pc_o
);
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic             inflight_q, inflight_d;
    logic [31:0]      inflight_pc_q, inflight_pc_d;
    logic [1:0][31:0] inst_q, inst_d;
    logic [1:0][31:0] pc_q, pc_d;
    logic [1:0]       count_q, count_d;
    logic             pop, push, issue_en, slot;

    assign mem_address_o = fetch_pc_q[11:2];
    assign out_valid_o   = count_q != 2'd0;
    assign out_inst_o    = inst_q[0];
    assign out_pc_o      = pc_q[0];
    assign pop           = out_valid_o & out_ready_i;
    assign push          = inflight_q;
    // Issue only when the returning word is guaranteed a FIFO slot.
    assign issue_en      = fetch_en_i & ~redirect_valid_i &
                           (((count_q + {1'b0, inflight_q}) < 2'd2) | pop);
    // Entry 0 is the head; a push lands behind whatever survives the pop.
    assign slot          = (count_q == 2'd1) & ~pop;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        inst_d        = inst_q;
        pc_d          = pc_q;
        count_d       = count_q;
        if (redirect_valid_i) begin
            fetch_pc_d = {redirect_pc_i[31:2], 2'b00};
            count_d    = 2'd0;
        end else begin
            if (issue_en) begin
                inflight_d    = 1'b1;
                inflight_pc_d = fetch_pc_q;
                fetch_pc_d    = fetch_pc_q + 32'd4;
            end
            if (pop) begin
                inst_d[0] = inst_q[1];
                pc_d[0]   = pc_q[1];
            end
            if (push) begin
                inst_d[slot] = mem_q_i;
                pc_d[slot]   = inflight_pc_q;
            end
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= 32'd0;
            inst_q        <= '0;
            pc_q          <= '0;
            count_q       <= 2'd0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            inst_q        <= inst_d;
            pc_q          <= pc_d;
            count_q       <= count_d;
        end
    end
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: scoreboard bench for inst_fetch with a one-cycle-latency memory model.
module tb_inst_fetch;
    logic        clock, reset_n, fetch_en, redirect_valid, out_valid, out_ready;
    logic [31:0] redirect_pc, mem_q, out_inst, out_pc;
    logic [9:0]  mem_address;
    logic [63:0] exp_q[$];
    int          errors = 0, checks = 0, n_xfer = 0;
    logic [31:0] hp;
    int          x0;

    inst_fetch #(.RESET_PC(32'h0)) dut (
        .clock_i(clock), .reset_n_i(reset_n), .fetch_en_i(fetch_en),
        .redirect_valid_i(redirect_valid), .redirect_pc_i(redirect_pc),
        .mem_address_o(mem_address), .mem_q_i(mem_q), .out_valid_o(out_valid),
        .out_ready_i(out_ready), .out_inst_o(out_inst), .out_pc_o(out_pc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) mem_q <= 32'hA000_0000 + {22'd0, mem_address};

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] addr_of(input logic [31:0] p);
        return {22'd0, p[11:2]};
    endfunction

    task automatic fill(input logic [31:0] start, input int n);
        logic [31:0] p;
        for (int i = 0; i < n; i++) begin
            p = start + 32'(4 * i);
            exp_q.push_back({p, 32'hA000_0000 + addr_of(p)});
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // A transfer happens at the coming edge when valid & ready with no redirect or reset.
    always @(negedge clock) begin
        if (reset_n && !redirect_valid && out_valid && out_ready) begin
            logic [63:0] e;
            n_xfer++;
            if (exp_q.size() == 0) chk("sb_underflow", 32'(exp_q.size()), 32'd1);
            else begin
                e = exp_q.pop_front();
                chk("xfer_pc", out_pc, e[63:32]);
                chk("xfer_inst", out_inst, e[31:0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset_n = 0; fetch_en = 1; out_ready = 1; redirect_valid = 0; redirect_pc = 0;
        repeat (3) step();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_pc", out_pc, 32'd0);
        chk("rst_inst", out_inst, 32'd0);
        chk("rst_addr", {22'd0, mem_address}, 32'd0);
        reset_n = 1; fill(32'h0, 64);
        step();
        chk("rel_e1_valid", 32'(out_valid), 32'd0);
        chk("rel_e1_addr", {22'd0, mem_address}, 32'd1);
        step();
        chk("rel_e2_valid", 32'(out_valid), 32'd1);
        chk("rel_e2_pc", out_pc, 32'd0);
        chk("rel_e2_inst", out_inst, 32'hA000_0000);
        repeat (8) begin step(); chk("stream_valid", 32'(out_valid), 32'd1); end
        // stall: head frozen, FIFO fills, fetch stops two words ahead of head
        out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_pc", out_pc, exp_q[0][63:32]);
            chk("stall_inst", out_inst, exp_q[0][31:0]);
            hp = exp_q[0][63:32] + 32'd8;
            chk("stall_addr", {22'd0, mem_address}, addr_of(hp));
        end
        out_ready = 1;
        repeat (6) begin step(); chk("resume_valid", 32'(out_valid), 32'd1); end
        // redirect with a full FIFO and ready high: head discarded
        out_ready = 0; step();
        redirect_valid = 1; redirect_pc = 32'h0000_0103; out_ready = 1;
        step();
        redirect_valid = 0; exp_q.delete(); fill(32'h100, 32);
        chk("redir_valid", 32'(out_valid), 32'd0);
        chk("redir_addr", {22'd0, mem_address}, 32'h40);
        step();
        chk("redir_e1_valid", 32'(out_valid), 32'd0);
        step();
        chk("redir_e2_valid", 32'(out_valid), 32'd1);
        chk("redir_e2_pc", out_pc, 32'h100);
        chk("redir_e2_inst", out_inst, 32'hA000_0040);
        step();
        chk("redir_e3_pc", out_pc, 32'h104);
        chk("redir_e3_inst", out_inst, 32'hA000_0041);
        repeat (3) step();
        // redirect near the 4 KiB wrap of the word address
        redirect_valid = 1; redirect_pc = 32'h0000_0FFC;
        step();
        redirect_valid = 0; exp_q.delete(); fill(32'hFFC, 16);
        chk("wrap_addr0", {22'd0, mem_address}, 32'd1023);
        step();
        chk("wrap_addr1", {22'd0, mem_address}, 32'd0);
        step();
        chk("wrap_pc0", out_pc, 32'hFFC);
        chk("wrap_inst0", out_inst, 32'hA000_03FF);
        step();
        chk("wrap_pc1", out_pc, 32'h1000);
        chk("wrap_inst1", out_inst, 32'hA000_0000);
        repeat (4) step();
        // asynchronous reset mid-stream with a full FIFO
        out_ready = 0; step();
        reset_n = 0; #1;
        exp_q.delete();
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_pc", out_pc, 32'd0);
        chk("arst_inst", out_inst, 32'd0);
        chk("arst_addr", {22'd0, mem_address}, 32'd0);
        out_ready = 1;
        step(); step();
        reset_n = 1; fill(32'h0, 32);
        step();
        chk("arel_e1_valid", 32'(out_valid), 32'd0);
        step();
        chk("arel_e2_valid", 32'(out_valid), 32'd1);
        chk("arel_e2_pc", out_pc, 32'd0);
        chk("arel_e2_inst", out_inst, 32'hA000_0000);
        repeat (5) step();
        // fetch disabled: head and in-flight word drain, then idle
        hp = exp_q[0][63:32] + 32'd8; x0 = n_xfer;
        fetch_en = 0;
        step();
        chk("drain_e1_valid", 32'(out_valid), 32'd1);
        chk("drain_e1_addr", {22'd0, mem_address}, addr_of(hp));
        step();
        chk("drain_e2_valid", 32'(out_valid), 32'd0);
        repeat (3) begin
            step();
            chk("drain_addr", {22'd0, mem_address}, addr_of(hp));
            chk("drain_idle_valid", 32'(out_valid), 32'd0);
        end
        chk("drain_xfers", 32'(n_xfer - x0), 32'd2);
        fetch_en = 1;
        step(); step();
        chk("refetch_valid", 32'(out_valid), 32'd1);
        chk("refetch_pc", out_pc, hp);
        repeat (3) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
